// File: rtl/snake_grid_reader.sv
// rtl/snake_grid_reader.sv - read-side client of the 16x16 snake grid memory (point query and full-grid scan)
//
// Purpose:
//   Serves point queries (returns the 2-bit cell at (x,y)) and full-grid scans
//   (counts occupied cells, reports the first empty cell) on the memory's
//   second read port. Read data arrives RD_LAT cycles after the address.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   q_req, q_x, q_y       point-query request and cell coordinates
//   scan_req              full-scan request (wins over q_req)
//   busy                  high whenever a request is in progress
//   rd_x, rd_y, rd_data   memory read address pair and returned cell code
//   q_valid, q_data       one-cycle query result pulse and cell contents
//   scan_done             one-cycle pulse when a scan has finished
//   occ_count             occupied cells seen by the last scan (0..256)
//   free_found, free_x/y  first empty cell of the last scan, in scan order
//
// Configuration:
//   SNAKE_READER_RANDOM_START_EN - when defined, an 8-bit LFSR picks the scan
//   start cell and the scan wraps through (0,0) until every cell is visited.

module snake_grid_reader #(
    parameter int         GRID_W     = 16,
    parameter int         GRID_H     = 16,
    parameter int         RD_LAT     = 1,
    parameter logic [1:0] EMPTY_CODE = 2'b00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       q_req,
    input  logic [3:0] q_x,
    input  logic [3:0] q_y,
    input  logic       scan_req,
    output logic       busy,
    output logic [3:0] rd_x,
    output logic [3:0] rd_y,
    input  logic [1:0] rd_data,
    output logic       q_valid,
    output logic [1:0] q_data,
    output logic       scan_done,
    output logic [8:0] occ_count,
    output logic       free_found,
    output logic [3:0] free_x,
    output logic [3:0] free_y
);

    localparam logic [3:0] X_MAX     = 4'(GRID_W - 1);
    localparam logic [3:0] Y_MAX     = 4'(GRID_H - 1);
    localparam logic [8:0] LAST_CELL = 9'(GRID_W * GRID_H - 1);
    localparam logic [1:0] LAT_V     = 2'(RD_LAT);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_Q_WAIT  = 2'd1,
        ST_SCAN    = 2'd2,
        ST_S_DRAIN = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic [1:0]             wait_cnt_q, wait_cnt_d;
    logic [8:0]             cell_cnt_q, cell_cnt_d;
    logic [RD_LAT-1:0]      dl_vld_q, dl_vld_d;
    logic [RD_LAT-1:0][3:0] dl_x_q, dl_x_d, dl_y_q, dl_y_d;
    logic                   q_valid_q, q_valid_d;
    logic [1:0]             q_data_q, q_data_d;
    logic                   scan_done_q, scan_done_d;
    logic [8:0]             occ_count_q, occ_count_d;
    logic                   free_found_q, free_found_d;
    logic [3:0]             free_x_q, free_x_d, free_y_q, free_y_d;
    logic [3:0]             start_x, start_y;

`ifdef SNAKE_READER_RANDOM_START_EN
    logic [7:0] lfsr_q, lfsr_d;

    // x^8+x^6+x^5+x^4+1, free-running so consecutive scans start elsewhere
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr_q <= 8'h01;
        else        lfsr_q <= lfsr_d;
    end

    assign start_x = lfsr_q[7:4];
    assign start_y = lfsr_q[3:0];
`else
    assign start_x = 4'd0;
    assign start_y = 4'd0;
`endif

    // State register and all datapath flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            rd_x_q       <= '0;
            rd_y_q       <= '0;
            wait_cnt_q   <= '0;
            cell_cnt_q   <= '0;
            dl_vld_q     <= '0;
            dl_x_q       <= '0;
            dl_y_q       <= '0;
            q_valid_q    <= 1'b0;
            q_data_q     <= '0;
            scan_done_q  <= 1'b0;
            occ_count_q  <= '0;
            free_found_q <= 1'b0;
            free_x_q     <= '0;
            free_y_q     <= '0;
        end else begin
            state_q      <= state_d;
            rd_x_q       <= rd_x_d;
            rd_y_q       <= rd_y_d;
            wait_cnt_q   <= wait_cnt_d;
            cell_cnt_q   <= cell_cnt_d;
            dl_vld_q     <= dl_vld_d;
            dl_x_q       <= dl_x_d;
            dl_y_q       <= dl_y_d;
            q_valid_q    <= q_valid_d;
            q_data_q     <= q_data_d;
            scan_done_q  <= scan_done_d;
            occ_count_q  <= occ_count_d;
            free_found_q <= free_found_d;
            free_x_q     <= free_x_d;
            free_y_q     <= free_y_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (scan_req)   state_d = ST_SCAN;
                else if (q_req) state_d = ST_Q_WAIT;
            end
            ST_Q_WAIT:  if (wait_cnt_q == LAT_V)       state_d = ST_IDLE;
            ST_SCAN:    if (cell_cnt_q == LAST_CELL)   state_d = ST_S_DRAIN;
            ST_S_DRAIN: if (dl_vld_q == '0)            state_d = ST_IDLE;
            default:                                   state_d = ST_IDLE;
        endcase
    end

    // Datapath / output next values
    always_comb begin
        rd_x_d       = rd_x_q;
        rd_y_d       = rd_y_q;
        wait_cnt_d   = wait_cnt_q;
        cell_cnt_d   = cell_cnt_q;
        q_valid_d    = 1'b0;
        q_data_d     = q_data_q;
        scan_done_d  = 1'b0;
        occ_count_d  = occ_count_q;
        free_found_d = free_found_q;
        free_x_d     = free_x_q;
        free_y_d     = free_y_q;

        // Delay line tags each address issued during SCAN so the sample that
        // comes back RD_LAT cycles later is paired with its own cell.
        dl_vld_d    = '0;
        dl_x_d      = '0;
        dl_y_d      = '0;
        dl_vld_d[0] = (state_q == ST_SCAN);
        dl_x_d[0]   = rd_x_q;
        dl_y_d[0]   = rd_y_q;
        for (int i = 1; i < RD_LAT; i++) begin
            dl_vld_d[i] = dl_vld_q[i-1];
            dl_x_d[i]   = dl_x_q[i-1];
            dl_y_d[i]   = dl_y_q[i-1];
        end

        if (dl_vld_q[RD_LAT-1]) begin
            if (rd_data != EMPTY_CODE) begin
                occ_count_d = occ_count_q + 9'd1;
            end else if (!free_found_q) begin
                free_found_d = 1'b1;
                free_x_d     = dl_x_q[RD_LAT-1];
                free_y_d     = dl_y_q[RD_LAT-1];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (scan_req) begin
                    occ_count_d  = '0;
                    free_found_d = 1'b0;
                    rd_x_d       = start_x;
                    rd_y_d       = start_y;
                    cell_cnt_d   = '0;
                end else if (q_req) begin
                    rd_x_d     = q_x;
                    rd_y_d     = q_y;
                    wait_cnt_d = '0;
                end
            end
            ST_Q_WAIT: begin
                if (wait_cnt_q == LAT_V) begin
                    q_valid_d = 1'b1;
                    q_data_d  = rd_data;
                end else begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end
            end
            ST_SCAN: begin
                cell_cnt_d = cell_cnt_q + 9'd1;
                if (rd_x_q == X_MAX) begin
                    rd_x_d = '0;
                    rd_y_d = (rd_y_q == Y_MAX) ? 4'd0 : rd_y_q + 4'd1;
                end else begin
                    rd_x_d = rd_x_q + 4'd1;
                end
            end
            ST_S_DRAIN: begin
                if (dl_vld_q == '0) scan_done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign busy       = (state_q != ST_IDLE);
    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign q_valid    = q_valid_q;
    assign q_data     = q_data_q;
    assign scan_done  = scan_done_q;
    assign occ_count  = occ_count_q;
    assign free_found = free_found_q;
    assign free_x     = free_x_q;
    assign free_y     = free_y_q;

endmodule

// File: tb/tb_snake_grid_reader.sv
// tb/tb_snake_grid_reader.sv - self-checking bench for snake_grid_reader (RD_LAT=1 and RD_LAT=3 instances)

module tb_snake_grid_reader;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       q_req = 1'b0;
    logic [3:0] q_x = '0;
    logic [3:0] q_y = '0;
    logic       scan_req = 1'b0;

    logic       busy1, busy3;
    logic [3:0] rd_x1, rd_y1, rd_x3, rd_y3;
    logic [1:0] rd_data1, rd_data3;
    logic       q_valid1, q_valid3;
    logic [1:0] q_data1, q_data3;
    logic       scan_done1, scan_done3;
    logic [8:0] occ1, occ3;
    logic       ff1, ff3;
    logic [3:0] fx1, fy1, fx3, fy3;

    logic [1:0] grid [16][16];   // [y][x]
    logic [1:0] m3_p [3];

    int vectors = 0;
    int miscompares = 0;

    // reference results of the last scan, derived from the grid contents
    int m_occ = 0;
    int m_ff = 0;
    int m_fx = 0;
    int m_fy = 0;

    always #5 clk = ~clk;

    snake_grid_reader #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset_n), .q_req(q_req), .q_x(q_x), .q_y(q_y),
        .scan_req(scan_req), .busy(busy1), .rd_x(rd_x1), .rd_y(rd_y1),
        .rd_data(rd_data1), .q_valid(q_valid1), .q_data(q_data1),
        .scan_done(scan_done1), .occ_count(occ1), .free_found(ff1),
        .free_x(fx1), .free_y(fy1)
    );

    snake_grid_reader #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset_n), .q_req(q_req), .q_x(q_x), .q_y(q_y),
        .scan_req(scan_req), .busy(busy3), .rd_x(rd_x3), .rd_y(rd_y3),
        .rd_data(rd_data3), .q_valid(q_valid3), .q_data(q_data3),
        .scan_done(scan_done3), .occ_count(occ3), .free_found(ff3),
        .free_x(fx3), .free_y(fy3)
    );

    // memory models: registered read, 1 and 3 cycles of latency
    always @(posedge clk) begin
        rd_data1 <= grid[rd_y1][rd_x1];
        m3_p[0]  <= grid[rd_y3][rd_x3];
        m3_p[1]  <= m3_p[0];
        m3_p[2]  <= m3_p[1];
    end
    assign rd_data3 = m3_p[2];

    typedef struct {
        int x;
        int y;
        int code;
    } qvec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_scan();
        m_occ = 0;
        m_ff  = 0;
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++)
                if (grid[y][x] != 2'b00) m_occ++;
                else if (m_ff == 0) begin
                    m_ff = 1; m_fx = x; m_fy = y;
                end
    endtask

    task automatic fill_grid(input int code);
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) grid[y][x] = 2'(code);
    endtask

    task automatic do_query(input int x, input int y, input int exp);
        int lat1 = -1, lat3 = -1, d1 = -1, d3 = -1;
        @(negedge clk);
        q_x = 4'(x); q_y = 4'(y); q_req = 1'b1;
        @(posedge clk); #1;
        q_req = 1'b0;
        check("query_busy1", int'(busy1), 1);
        check("query_busy3", int'(busy3), 1);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (q_valid1 && lat1 < 0) begin lat1 = n; d1 = int'(q_data1); end
            if (q_valid3 && lat3 < 0) begin lat3 = n; d3 = int'(q_data3); end
        end
        check("query_lat1", lat1, 2);
        check("query_lat3", lat3, 4);
        check("query_data1", d1, exp);
        check("query_data3", d3, exp);
    endtask

    // q_both: raise q_req together with scan_req; q_mid: pulse q_req mid-scan
    task automatic do_scan(input string tag, input bit q_both, input bit q_mid);
        int done1 = -1, done3 = -1, qv = 0;
        int o1 = 0, o3 = 0, f1 = 0, f3 = 0, x1 = 0, y1 = 0, x3 = 0, y3 = 0;
        model_scan();
        @(negedge clk);
        scan_req = 1'b1;
        q_req = q_both;
        @(posedge clk); #1;
        scan_req = 1'b0; q_req = 1'b0;
        for (int n = 1; n <= 280; n++) begin
            @(posedge clk); #1;
            q_req = (q_mid && n == 50);
            if (q_valid1 || q_valid3) qv++;
            if (scan_done1 && done1 < 0) begin
                done1 = n; o1 = int'(occ1); f1 = int'(ff1); x1 = int'(fx1); y1 = int'(fy1);
            end
            if (scan_done3 && done3 < 0) begin
                done3 = n; o3 = int'(occ3); f3 = int'(ff3); x3 = int'(fx3); y3 = int'(fy3);
            end
        end
        q_req = 1'b0;
        check({tag, "_done1"}, done1, 258);
        check({tag, "_done3"}, done3, 260);
        check({tag, "_occ1"}, o1, m_occ);
        check({tag, "_occ3"}, o3, m_occ);
        check({tag, "_ff1"}, f1, m_ff);
        check({tag, "_ff3"}, f3, m_ff);
        check({tag, "_fx1"}, x1, m_fx);
        check({tag, "_fy1"}, y1, m_fy);
        check({tag, "_fx3"}, x3, m_fx);
        check({tag, "_fy3"}, y3, m_fy);
        check({tag, "_no_qvalid"}, qv, 0);
        check({tag, "_stable_occ1"}, int'(occ1), m_occ);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, int'(busy1) + int'(busy3), 0);
        check({tag, "_pulses"}, int'(q_valid1 | q_valid3 | scan_done1 | scan_done3), 0);
        check({tag, "_occ"}, int'(occ1) + int'(occ3), 0);
        check({tag, "_free"}, int'(ff1) + int'(ff3) + int'(fx1) + int'(fy1) + int'(fx3) + int'(fy3), 0);
        check({tag, "_rd_addr"}, int'(rd_x1) + int'(rd_y1) + int'(rd_x3) + int'(rd_y3), 0);
        check({tag, "_qdata"}, int'(q_data1) + int'(q_data3), 0);
    endtask

    initial begin
        qvec_t qtab[6];
        int    dones;
        qtab[0] = '{x: 3,  y: 5,  code: 1};
        qtab[1] = '{x: 0,  y: 0,  code: 3};
        qtab[2] = '{x: 15, y: 15, code: 2};
        qtab[3] = '{x: 15, y: 0,  code: 1};
        qtab[4] = '{x: 0,  y: 15, code: 3};
        qtab[5] = '{x: 7,  y: 2,  code: 0};

        fill_grid(0);
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // point queries from the table
        for (int i = 0; i < 6; i++) grid[qtab[i].y][qtab[i].x] = 2'(qtab[i].code);
        for (int i = 0; i < 6; i++) do_query(qtab[i].x, qtab[i].y, qtab[i].code);

        // empty grid, then only (7,2),(9,2) empty, then full grid
        fill_grid(0);
        do_scan("empty", 1'b0, 1'b0);
        check("empty_fx_const", int'(fx1) * 16 + int'(fy1), 0);
        fill_grid(2);
        grid[2][7] = 2'b00;
        grid[2][9] = 2'b00;
        do_scan("first_empty", 1'b0, 1'b0);
        check("first_empty_const", int'(occ3) * 256 + int'(fx3) * 16 + int'(fy3), 254 * 256 + 7 * 16 + 2);
        fill_grid(2);
        do_scan("full", 1'b0, 1'b0);
        check("full_hold_const", int'(ff1) * 256 + int'(fx1) * 16 + int'(fy1), 7 * 16 + 2);

        // priority and ignored mid-scan query
        for (int y = 0; y < 16; y++)
            for (int x = 0; x < 16; x++) grid[y][x] = 2'($urandom_range(0, 3));
        do_scan("priority", 1'b1, 1'b1);

        // asynchronous reset at cell 100
        @(negedge clk);
        scan_req = 1'b1;
        @(posedge clk); #1;
        scan_req = 1'b0;
        repeat (99) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("abort");
        dones = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (scan_done1 || scan_done3) dones++;
        end
        check("abort_no_done", dones, 0);
        @(negedge clk);
        reset_n = 1'b1;
        m_fx = 0; m_fy = 0;
        do_scan("after_reset", 1'b0, 1'b0);

        // randomized grids and queries
        for (int t = 0; t < 4; t++) begin
            int p;
            p = (t == 3) ? 100 : $urandom_range(0, 100);
            for (int y = 0; y < 16; y++)
                for (int x = 0; x < 16; x++)
                    grid[y][x] = ($urandom_range(0, 99) < p) ? 2'($urandom_range(1, 3)) : 2'b00;
            do_scan("random", 1'b0, 1'b0);
            for (int k = 0; k < 4; k++) begin
                int rx, ry;
                rx = $urandom_range(0, 15);
                ry = $urandom_range(0, 15);
                do_query(rx, ry, int'(grid[ry][rx]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snake_grid_reader.md
Name: snake_grid_reader

Overview:
- Read-side client of the 16x16 snake grid memory; the counterpart to the snake writer, which only writes cells.
- Serves two request types for game logic on the fast clock:
  - point query: returns the 2-bit cell at (x,y) for collision checks;
  - full-grid scan: counts occupied cells and reports the first empty cell for food placement.
- Drives the memory's second read address pair and consumes its registered read data.

Parameters:
- GRID_W, 16, cells per row; x range 0..GRID_W-1.
- GRID_H, 16, cells per column; y range 0..GRID_H-1.
- RD_LAT, 1, memory read latency in clk cycles (1..3).
- EMPTY_CODE, 2'b00, cell code meaning empty.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- q_req  in  1  point-query request; sampled only in IDLE.
- q_x  in  4  query column.
- q_y  in  4  query row.
- scan_req  in  1  full-scan request; sampled only in IDLE.
- busy  out  1  high in any non-IDLE state.
- rd_x  out  4  memory read column.
- rd_y  out  4  memory read row.
- rd_data  in  2  memory read data, valid RD_LAT cycles after address.
- q_valid  out  1  one-cycle pulse; q_data valid.
- q_data  out  2  cell contents for the last query.
- scan_done  out  1  one-cycle pulse at end of scan.
- occ_count  out  9  non-empty cells found by last scan (0..256).
- free_found  out  1  at least one empty cell seen in last scan.
- free_x  out  4  column of first empty cell.
- free_y  out  4  row of first empty cell.

Behaviour:
- Reset (async, reset==0): state IDLE; all outputs and internal counters 0.
- FSM states: IDLE, Q_WAIT, SCAN, S_DRAIN.
- IDLE:
  - If scan_req, go to SCAN; scan_req has priority when both requests are high.
  - Else if q_req, latch q_x/q_y onto rd_x/rd_y and go to Q_WAIT.
  - Requests arriving while busy are ignored, not queued.
- Q_WAIT:
  - Wait RD_LAT cycles, then capture rd_data into q_data and pulse q_valid.
  - Return to IDLE in the same cycle.
  - Query latency is RD_LAT+1 cycles from q_req sample to q_valid.
- SCAN:
  - On entry: clear occ_count and free_found; scan start cell is (0,0).
  - Raster order: x increments each cycle; at x==GRID_W-1, x wraps to 0 and y increments.
  - One address issued per cycle.
  - A delay line of RD_LAT stages carries a valid bit plus the address, pairing each rd_data with its cell.
  - After issuing the last cell (GRID_W-1, GRID_H-1), go to S_DRAIN.
- Data rules, applied in both SCAN and S_DRAIN for each valid returned sample:
  - If the sample != EMPTY_CODE, occ_count++.
  - If the sample == EMPTY_CODE and free_found==0, latch its address into free_x/free_y and set free_found.
- S_DRAIN:
  - Wait until the delay line is empty, then pulse scan_done and go to IDLE.
  - Total scan time is GRID_W*GRID_H + RD_LAT + 1 cycles from start.
- occ_count is 9 bits so a full grid (256) does not overflow.
- free_x/free_y hold their last value when free_found==0.
- Scan results remain stable until the next scan starts.
- Reset asserted mid-operation aborts immediately to IDLE with all outputs 0; no done or valid pulse is issued.

Optional Feature:
- Macro: SNAKE_READER_RANDOM_START_EN.
- Defined:
  - An internal 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'h01 on reset) advances every clk.
  - On scan start, the scan begins at cell {LFSR[7:4], LFSR[3:0]} and wraps from (GRID_W-1, GRID_H-1) to (0,0).
  - It stops after GRID_W*GRID_H cells, so food placement varies between scans.
- Undefined: the LFSR is absent and the scan always starts at (0,0).

Test Plan:
- Point query: memory model holds 2'b01 at (3,5); pulse q_req with q_x=3, q_y=5 -> q_valid exactly RD_LAT+1 cycles later, q_data=2'b01, busy high in between.
- Empty grid: all cells 00, scan_req -> scan_done at cycle 258 (RD_LAT=1), occ_count=0, free_found=1, free_x=0, free_y=0.
- Full grid: all cells 2'b10 -> occ_count=256, free_found=0, free_x/free_y unchanged from prior scan.
- First empty cell: only (7,2) and (9,2) are empty -> free_x=7, free_y=2, occ_count=254; repeat with RD_LAT=3 -> identical results, scan_done delayed by 2 cycles.
- Priority and busy: q_req and scan_req high together -> scan runs, no q_valid; q_req pulsed mid-scan -> ignored.
- Async reset at cell 100 of a scan -> outputs 0 immediately, no scan_done; a new scan after release completes normally.
